// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 scan-code sequencer producing key events, held-key display and BCD press count
module ps2_key_event_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       clr_cnt,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       seg_en,
    output logic [7:0] press_cnt,
    output logic       key_event
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       BYTE_E0 = 8'hE0;
    localparam logic [7:0]       BYTE_F0 = 8'hF0;
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] tmo_q;
    logic [7:0]       key_code_q;
    logic             key_ext_q;
    logic             seg_en_q;
    logic [7:0]       press_q;
    logic             key_event_q;
    logic             byte_ready_q;

    logic       xfer;
    logic       is_e0;
    logic       is_f0;
    logic       act_ext;
    logic       hit;
    logic       do_make;
    logic       do_brk;
    logic [7:0] press_d;

    always_comb begin
        xfer    = byte_valid & byte_ready_q;
        is_e0   = (byte_data == BYTE_E0);
        is_f0   = (byte_data == BYTE_F0);
        act_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        // Same code and same prefix as the held key: typematic repeat or matching release.
        hit     = seg_en_q && (key_code_q == byte_data) && (key_ext_q == act_ext);
        do_make = xfer && !is_e0 && !is_f0 && ((state_q == S_IDLE) || (state_q == S_EXT));
        do_brk  = xfer && !is_e0 && !is_f0 && ((state_q == S_BRK) || (state_q == S_EXT_BRK));
    end

    always_comb begin
        press_d = press_q;
        if (press_q[3:0] == 4'd9) begin
            press_d[3:0] = 4'd0;
            press_d[7:4] = (press_q[7:4] == 4'd9) ? 4'd0 : press_q[7:4] + 4'd1;
        end else begin
            press_d[3:0] = press_q[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            seg_en_q     <= 1'b0;
            press_q      <= 8'h00;
            key_event_q  <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            byte_ready_q <= 1'b1;
            key_event_q  <= 1'b0;

            if (xfer) begin
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (is_e0)      state_q <= S_EXT;
                        else if (is_f0) state_q <= S_BRK;
                    end
                    S_EXT: begin
                        if (is_f0)       state_q <= S_EXT_BRK;
                        else if (!is_e0) state_q <= S_IDLE;
                    end
                    default: begin
                        if (!is_e0 && !is_f0) state_q <= S_IDLE;
                    end
                endcase
            end else if (state_q == S_IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_MAX) begin
                state_q <= S_IDLE;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end

            if (do_make && !hit) begin
                key_code_q  <= byte_data;
                key_ext_q   <= act_ext;
                seg_en_q    <= 1'b1;
                key_event_q <= 1'b1;
                press_q     <= press_d;
            end

            // key_code is kept after release so the last key stays visible for debug.
            if (do_brk && hit) begin
                seg_en_q <= 1'b0;
            end

            if (clr_cnt) begin
                press_q <= 8'h00;
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign seg_en     = seg_en_q;
    assign press_cnt  = press_q;
    assign key_event  = key_event_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - randomized self-checking bench with a behavioural key-event model
module tb_ps2_key_event_ctrl;

    localparam int T = 16;

    logic       clk;
    logic       resetn;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       clr_cnt;
    logic [7:0] key_code;
    logic       key_ext;
    logic       seg_en;
    logic [7:0] press_cnt;
    logic       key_event;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: held key, decimal press count, pending prefix flags.
    logic [7:0] m_code;
    logic       m_ext;
    logic       m_held;
    int         m_cnt;
    logic       m_pext;
    logic       m_pbrk;
    int         m_idle;
    logic       m_event;

    ps2_key_event_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .clr_cnt    (clr_cnt),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .seg_en     (seg_en),
        .press_cnt  (press_cnt),
        .key_event  (key_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_code  = 8'h00;
        m_ext   = 1'b0;
        m_held  = 1'b0;
        m_cnt   = 0;
        m_pext  = 1'b0;
        m_pbrk  = 1'b0;
        m_idle  = 0;
        m_event = 1'b0;
    endtask

    task automatic model_xfer(input logic [7:0] b, input logic clr);
        logic hit;
        m_event = 1'b0;
        if ((m_pext || m_pbrk) && m_idle >= T) begin
            m_pext = 1'b0;
            m_pbrk = 1'b0;
        end
        hit = m_held && (m_code == b) && (m_ext == m_pext);
        if (b == 8'hE0) begin
            if (!m_pbrk) m_pext = 1'b1;
        end else if (b == 8'hF0) begin
            m_pbrk = 1'b1;
        end else begin
            if (m_pbrk) begin
                if (hit) m_held = 1'b0;
            end else if (!hit) begin
                m_code  = b;
                m_ext   = m_pext;
                m_held  = 1'b1;
                m_event = 1'b1;
                m_cnt   = (m_cnt + 1) % 100;
            end
            m_pext = 1'b0;
            m_pbrk = 1'b0;
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".key_code"},  {24'd0, key_code},  {24'd0, m_code});
        check({tag, ".key_ext"},   {31'd0, key_ext},   {31'd0, m_ext});
        check({tag, ".seg_en"},    {31'd0, seg_en},    {31'd0, m_held});
        check({tag, ".press_cnt"}, {24'd0, press_cnt}, {24'd0, to_bcd(m_cnt)});
        check({tag, ".key_event"}, {31'd0, key_event}, {31'd0, m_event});
    endtask

    task automatic send(input logic [7:0] b, input logic clr, input int gap);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        clr_cnt    = clr;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = $urandom_range(255, 0);
        clr_cnt    = 1'b0;
        model_xfer(b, clr);
        check_outputs("xfer");
        m_event = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) check("idle.key_event", {31'd0, key_event}, 32'd0);
        end
        m_idle = gap;
    endtask

    task automatic do_reset(input string tag);
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        check({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".byte_ready_up"}, {31'd0, byte_ready}, 32'd1);
    endtask

    logic [7:0] pool [8];

    initial begin
        pool[0] = 8'h1C; pool[1] = 8'h75; pool[2] = 8'hE0; pool[3] = 8'hF0;
        pool[4] = 8'h32; pool[5] = 8'hF0; pool[6] = 8'h1C; pool[7] = 8'hE0;
        resetn     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        clr_cnt    = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.byte_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, byte_ready}, 32'd1);

        // Press/release, typematic repeat, extended keys.
        send(8'h1C, 1'b0, 1);
        check("pressA.cnt", {24'd0, press_cnt}, 32'h01);
        send(8'h1C, 1'b0, 0);
        send(8'h1C, 1'b0, 0);
        send(8'hF0, 1'b0, 0);
        send(8'h1C, 1'b0, 2);
        check("relA.seg_en", {31'd0, seg_en}, 32'd0);
        check("relA.cnt", {24'd0, press_cnt}, 32'h01);
        send(8'hE0, 1'b0, 0);
        send(8'h75, 1'b0, 0);
        check("up.key_ext", {31'd0, key_ext}, 32'd1);
        send(8'hF0, 1'b0, 0);
        send(8'h75, 1'b0, 0);
        check("plain_brk.seg_en", {31'd0, seg_en}, 32'd1);
        send(8'hE0, 1'b0, 0);
        send(8'hF0, 1'b0, 0);
        send(8'h75, 1'b0, 1);
        check("ext_brk.seg_en", {31'd0, seg_en}, 32'd0);

        // 100 make/break pairs to cross 09->10 and 99->00.
        for (int i = 0; i < 100; i++) begin
            send(8'h10 + 8'(i % 7), 1'b0, 0);
            send(8'hF0, 1'b0, 0);
            send(8'h10 + 8'(i % 7), 1'b0, 0);
        end
        check("wrap.cnt", {24'd0, press_cnt}, 32'h02);
        while (m_cnt != 37) begin
            send(8'h21, 1'b0, 0);
            send(8'hF0, 1'b0, 0);
            send(8'h21, 1'b0, 0);
        end
        send(8'h22, 1'b1, 0);
        check("clr_make.cnt", {24'd0, press_cnt}, 32'h00);

        // Timeout boundary: T-1 idle cycles keeps the prefix, T drops it.
        do_reset("rst1");
        send(8'h1C, 1'b0, 0);
        send(8'hF0, 1'b0, T - 1);
        send(8'h1C, 1'b0, 0);
        check("tmo_keep.seg_en", {31'd0, seg_en}, 32'd0);
        send(8'hF0, 1'b0, T);
        send(8'h1C, 1'b0, 0);
        check("tmo_drop.cnt", {24'd0, press_cnt}, 32'h02);

        // Asynchronous reset in the middle of an E0 sequence.
        send(8'hE0, 1'b0, 0);
        do_reset("rst_mid");
        send(8'h75, 1'b0, 0);
        check("post_rst.key_ext", {31'd0, key_ext}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            int gsel;
            int gap;
            gsel = $urandom_range(19, 0);
            gap  = (gsel < 16) ? $urandom_range(3, 0) : $urandom_range(T + 1, T - 2);
            send(pool[$urandom_range(7, 0)], ($urandom_range(29, 0) == 0), gap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences raw PS/2 scan-code bytes from the keyboard receiver into key events: make, break, E0-extended and typematic repeat.
- Drives the display path: current key code, display enable and a BCD press counter for the seven-segment digits.
- Sits between the PS/2 byte receiver (valid/ready source) and the bcd7seg display instances.

Parameters:
- TIMEOUT_CYCLES, 1000000, idle cycles in a prefix state before the FSM abandons the partial sequence.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- byte_valid  input  1  receiver presents a scan-code byte.
- byte_data  input  8  scan-code byte; meaningful only while byte_valid=1.
- byte_ready  output  1  controller accepts a byte; a transfer occurs on a cycle where byte_valid & byte_ready.
- clr_cnt  input  1  synchronous clear of press_cnt.
- key_code  output  8  code of the currently held key (last make).
- key_ext  output  1  held key was E0-prefixed.
- seg_en  output  1  a key is held; gates the key-code digits.
- press_cnt  output  8  two-digit packed BCD count of new presses, range 00..99.
- key_event  output  1  one-cycle pulse on each accepted new press.

Behaviour:
- Reset values (asynchronous, while resetn=0): state=IDLE, key_code=8'h00, key_ext=0, seg_en=0, press_cnt=8'h00, key_event=0, timeout counter=0, byte_ready=0.
- byte_ready is 1 in every state from the first clock edge after resetn deasserts; there is no backpressure. Only transferred bytes are decoded.
- FSM states and transitions on a transfer:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Any other byte b -> MAKE handling with ext=0; stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - Other b -> MAKE with ext=1; go to IDLE.
  - BRK:
    - E0 or F0 -> stay in BRK (malformed sequence; no action).
    - Other b -> BREAK with ext=0; go to IDLE.
  - EXT_BRK:
    - E0 or F0 -> stay in EXT_BRK (malformed sequence; no action).
    - Other b -> BREAK with ext=1; go to IDLE.
- MAKE(b, ext):
  - If seg_en=1, key_code==b and key_ext==ext, it is a typematic repeat: no counter change, no key_event.
  - Otherwise load key_code=b and key_ext=ext, set seg_en=1, pulse key_event for exactly one cycle (the cycle after the transfer edge), and increment press_cnt in BCD.
  - BCD increment: low digit 9 -> 0 with carry into the high digit; 99 -> 00 wrap.
- BREAK(b, ext): if seg_en=1, b==key_code and ext==key_ext, clear seg_en. key_code is retained for debug. Otherwise no effect.
- Outputs update on the clock edge that accepts the final byte; latency from transfer to outputs is 1 cycle.
- Timeout:
  - In EXT, BRK or EXT_BRK the counter increments on each cycle without a transfer.
  - When the count reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE on the next edge without any key action.
  - The counter resets to 0 on every transfer and whenever the FSM is in IDLE.
- clr_cnt: press_cnt <= 00 on that edge. If a new press is accepted on the same edge, clr_cnt wins: press_cnt=00 while key_event still pulses.
- Reset mid-sequence returns the FSM to IDLE and clears the held key. Any partial prefix is discarded.
- press_cnt digits are always valid BCD (0..9 each).

Test Plan:
- Press/release A: bytes 1C, F0, 1C -> after 1C: key_code=1C, seg_en=1, key_event one cycle, press_cnt=01; after F0,1C: seg_en=0, press_cnt=01.
- Typematic: 1C, 1C, 1C, then F0, 1C -> press_cnt=01, key_event once, seg_en cleared at end.
- Extended key: E0, 75 (up arrow) -> key_code=75, key_ext=1, press_cnt increments. E0, F0, 75 -> seg_en=0. Plain F0, 75 during the hold -> no effect.
- BCD wrap: 100 distinct make/break pairs -> press_cnt steps 09->10 and 99->00. clr_cnt at count 37 together with a new make -> 00 with key_event=1.
- Timeout: send F0, then idle TIMEOUT_CYCLES cycles (bench sets TIMEOUT_CYCLES=16), then 1C -> treated as a make (press_cnt+1), not a break.
- Async reset after E0 mid-sequence -> outputs at reset values immediately. Subsequent 75 -> make with key_ext=0.
